// File: rtl/oyun_mac.sv
// Match scorer: rounds go to player 1 on an exact x/y hit, else to player 2; 1-cycle round latency.
// round_ready is high only in PLAY; `OYUN_MAC_EARLY_END_EN ends the match as soon as a majority is reached.
module oyun_mac #(
  parameter int COORD_W  = 2,
  parameter int N_ROUNDS = 3,
  localparam int SW      = $clog2(N_ROUNDS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               round_valid,
  output logic               round_ready,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COORD_W-1:0] x2,
  input  logic [COORD_W-1:0] y2,
  output logic [SW-1:0]      score1,
  output logic [SW-1:0]      score2,
  output logic [SW-1:0]      round_cnt,
  output logic               last_hit,
  output logic               match_done,
  output logic               winner
);

  localparam int WIN_TH = (N_ROUNDS + 1) / 2;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] score1_q, score1_d;
  logic [SW-1:0] score2_q, score2_d;
  logic [SW-1:0] round_cnt_q, round_cnt_d;
  logic          last_hit_q, last_hit_d;
  logic          match_done_q, match_done_d;
  logic          winner_q, winner_d;

  logic          hit;
  logic [SW-1:0] cnt_inc, s1_inc, s2_inc;
  logic          end_now;

  always_comb begin
    hit     = (x1 == x2) && (y1 == y2);
    cnt_inc = round_cnt_q + SW'(1);
    s1_inc  = score1_q + SW'(hit);
    s2_inc  = score2_q + SW'(!hit);
`ifdef OYUN_MAC_EARLY_END_EN
    end_now = (cnt_inc == SW'(N_ROUNDS)) || (s1_inc == SW'(WIN_TH)) || (s2_inc == SW'(WIN_TH));
`else
    end_now = (cnt_inc == SW'(N_ROUNDS));
`endif
  end

  always_comb begin
    state_d      = state_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    round_cnt_d  = round_cnt_q;
    last_hit_d   = last_hit_q;
    match_done_d = match_done_q;
    winner_d     = winner_q;
    case (state_q)
      IDLE, DONE: begin
        // A new match starts identically from IDLE and from DONE.
        if (start) begin
          state_d      = PLAY;
          score1_d     = '0;
          score2_d     = '0;
          round_cnt_d  = '0;
          last_hit_d   = 1'b0;
          match_done_d = 1'b0;
          winner_d     = 1'b0;
        end
      end
      PLAY: begin
        if (round_valid) begin
          score1_d    = s1_inc;
          score2_d    = s2_inc;
          round_cnt_d = cnt_inc;
          last_hit_d  = hit;
          if (end_now) begin
            state_d      = DONE;
            match_done_d = 1'b1;
            winner_d     = (s1_inc > s2_inc);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      score1_q     <= '0;
      score2_q     <= '0;
      round_cnt_q  <= '0;
      last_hit_q   <= 1'b0;
      match_done_q <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      round_cnt_q  <= round_cnt_d;
      last_hit_q   <= last_hit_d;
      match_done_q <= match_done_d;
      winner_q     <= winner_d;
    end
  end

  assign round_ready = (state_q == PLAY);
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign round_cnt   = round_cnt_q;
  assign last_hit    = last_hit_q;
  assign match_done  = match_done_q;
  assign winner      = winner_q;

endmodule
